// File: rtl/mem_stage.sv
// MEM stage: runs the req/addr_ok/data_ok data-memory handshake for loads/stores and builds the MEM->WB bus.
// Loads/stores take 3+ cycles and hold DONE until wb allowin; non-memops pass through combinationally. Optional: MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [106:0] exe2mem_bus_ri,
    output logic [101:0] mem2wb_bus_o,
    input  logic         ctl_mem_valid_i,
    input  logic         ctl_wb_allowin_i,
    output logic         ctl_mem_over_o,
    output logic [4:0]   ctl_mem_dest_o,
    output logic [31:0]  ctl_mem_pc_o,
    output logic         dm_req_o,
    output logic         dm_we_o,
    output logic [3:0]   dm_wstrb_o,
    output logic [31:0]  dm_addr_o,
    output logic [31:0]  dm_wdata_o,
    input  logic         dm_addr_ok_i,
    input  logic         dm_data_ok_i,
    input  logic [31:0]  dm_rdata_i,
    output logic         ctl_mem_misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        ld, st, uns, we_f;
    logic [1:0]  size;
    logic [31:0] st_data, exe_result, pc;
    logic [4:0]  wdest;
    logic        memop, trap, bus_we, rdata_cap;
    logic [31:0] rdata_q, ld_val, wdata;
    logic [3:0]  strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign {ld, st, size, uns, st_data, exe_result, wdest, we_f, pc} = exe2mem_bus_ri;
    assign memop = ctl_mem_valid_i & (ld | st);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign, misalign_q;

    assign misalign = (size == 2'b01) ? exe_result[0] :
                      (size == 2'b00) ? 1'b0 : (|exe_result[1:0]);
    assign trap     = memop & misalign;
    assign bus_we   = we_f & ~trap;

    // Latched on leaving IDLE so the flag stays put for the whole DONE residency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state == S_IDLE) begin
            misalign_q <= trap;
        end
    end

    assign ctl_mem_misalign_o = (state == S_DONE) & misalign_q;
`else
    assign trap               = 1'b0;
    assign bus_we             = we_f;
    assign ctl_mem_misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rdata_cap = 1'b0;
        case (state)
            S_IDLE: begin
                if (trap) begin
                    state_nxt = S_DONE;
                end else if (memop) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (dm_addr_ok_i) begin
                    state_nxt = dm_data_ok_i ? S_DONE : S_WAIT;
                    rdata_cap = dm_data_ok_i;
                end
            end
            S_WAIT: begin
                if (dm_data_ok_i) begin
                    state_nxt = S_DONE;
                    rdata_cap = 1'b1;
                end
            end
            S_DONE: begin
                if (ctl_wb_allowin_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Only response beats update the load register; stray data_ok in IDLE/DONE is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (rdata_cap) begin
            rdata_q <= dm_rdata_i;
        end
    end

    always_comb begin
        strb  = 4'b1111;
        wdata = st_data;
        case (size)
            2'b00: begin
                strb  = 4'b0001 << exe_result[1:0];
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << {exe_result[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    assign ld_byte = rdata_q[{exe_result[1:0], 3'b000} +: 8];
    assign ld_half = exe_result[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ld_val = rdata_q;
        case (size)
            2'b00:   ld_val = {{24{~uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~uns & ld_half[15]}}, ld_half};
            default: ld_val = rdata_q;
        endcase
    end

    assign dm_req_o   = (state == S_REQ);
    assign dm_we_o    = st;
    assign dm_wstrb_o = st ? strb : 4'b0000;
    assign dm_addr_o  = exe_result;
    assign dm_wdata_o = wdata;

    assign ctl_mem_over_o = (state == S_DONE) |
                            ((state == S_IDLE) & ctl_mem_valid_i & ~(ld | st));
    assign ctl_mem_dest_o = wdest & {5{ctl_mem_valid_i}};
    assign ctl_mem_pc_o   = pc;

    assign mem2wb_bus_o = {wdest, bus_we, (ld ? ld_val : exe_result),
                           (memop ? exe_result : 32'h0), pc};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized load/store transactions against a behavioural model.
module tb_mem_stage;

    logic         clk, rst;
    logic [106:0] exe_bus;
    logic [101:0] wb_bus;
    logic         valid, allowin, over, req, dwe_o, addr_ok, data_ok, misalign;
    logic [4:0]   dest;
    logic [31:0]  pc_o, daddr_o, wdata_o, rdata;
    logic [3:0]   strb_o;
    int           n_cmp = 0;
    int           n_fail = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .exe2mem_bus_ri(exe_bus), .mem2wb_bus_o(wb_bus),
        .ctl_mem_valid_i(valid), .ctl_wb_allowin_i(allowin),
        .ctl_mem_over_o(over), .ctl_mem_dest_o(dest), .ctl_mem_pc_o(pc_o),
        .dm_req_o(req), .dm_we_o(dwe_o), .dm_wstrb_o(strb_o),
        .dm_addr_o(daddr_o), .dm_wdata_o(wdata_o),
        .dm_addr_ok_i(addr_ok), .dm_data_ok_i(data_ok), .dm_rdata_i(rdata),
        .ctl_mem_misalign_o(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [106:0] mk_bus(input logic ld, input logic st, input logic [1:0] size,
                                            input logic uns, input logic [31:0] sd, input logic [31:0] ea,
                                            input logic [4:0] wd, input logic we, input logic [31:0] pc);
        return {ld, st, size, uns, sd, ea, wd, we, pc};
    endfunction

    // Reference model: plain arithmetic on lanes rather than bit slicing.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        longint v;
        if (size == 2'd2) return rd;
        if (size == 2'd0) v = longint'((rd / (32'd1 << (8 * (a % 4)))) % 256);
        else              v = longint'((rd / (32'd1 << (16 * ((a / 2) % 2)))) % 65536);
        if (!uns && size == 2'd0 && v >= 128)   v = v - 256;
        if (!uns && size == 2'd1 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] a);
        int s;
        if (size == 2'd0)      s = 1 << (a % 4);
        else if (size == 2'd1) s = 3 << (2 * ((a / 2) % 2));
        else                   s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d % 256) * 32'h01010101;
        if (size == 2'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction through a scripted memory responder and records what the DUT showed.
    task automatic run_txn(input logic [106:0] ibus, input int a_wait, input bit same, input int d_wait,
                           input int hold, input logic [31:0] rd,
                           output int req_cnt, output int over_at, output logic [101:0] obus,
                           output bit stable, output logic [3:0] strb, output logic [31:0] wd,
                           output logic dwe, output logic [31:0] da, output bit mis_seen);
        int c_done, total;
        req_cnt = 0; over_at = -1; obus = '0; stable = 1'b1;
        strb = '0; wd = '0; dwe = 1'b0; da = '0; mis_seen = 1'b0;
        c_done = a_wait + (same ? 0 : d_wait) + 2;
        total  = c_done + hold + 1;
        for (int c = 0; c < total; c++) begin
            tick();
            exe_bus = ibus;
            valid   = 1'b1;
            allowin = (c == total - 1);
            addr_ok = (c == 1 + a_wait);
            data_ok = same ? (c == 1 + a_wait) : (c == 1 + a_wait + d_wait);
            rdata   = data_ok ? rd : $urandom;
            if (c == c_done && hold > 0) begin
                data_ok = 1'b1;
                rdata   = $urandom;
            end
            @(negedge clk);
            if (req) begin
                if (req_cnt == 0) begin
                    strb = strb_o; wd = wdata_o; dwe = dwe_o; da = daddr_o;
                end
                req_cnt++;
            end
            if (misalign) mis_seen = 1'b1;
            if (over) begin
                if (over_at < 0) begin
                    over_at = c;
                    obus    = wb_bus;
                end else if (wb_bus !== obus) begin
                    stable = 1'b0;
                end
            end
        end
        tick();
        valid = 1'b0; allowin = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; allowin = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        rdata = '0; exe_bus = '0;
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (over !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b want 0", over); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        n_cmp++; if (dest !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %h want 0", dest); end
        exe_bus = mk_bus(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h55, 5'd9, 1'b1, 32'h1C000010);
        valid = 1'b1;
        #1;
        n_cmp++; if (over !== 1'b1) begin n_fail++; $display("FAIL reset_alu_over: got %b want 1", over); end
        n_cmp++; if (dest !== 5'd9) begin n_fail++; $display("FAIL reset_alu_dest: got %h want 09", dest); end
        valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [101:0] exp;
        tick();
        exe_bus = mk_bus(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF0000, 32'h12345678, 5'd5, 1'b1, 32'h1C000000);
        valid = 1'b1;
        exp = {5'd5, 1'b1, 32'h12345678, 32'h0, 32'h1C000000};
        @(negedge clk);
        n_cmp++; if (over !== 1'b1) begin n_fail++; $display("FAIL alu_over: got %b want 1", over); end
        n_cmp++; if (wb_bus !== exp) begin n_fail++; $display("FAIL alu_bus: got %h want %h", wb_bus, exp); end
        n_cmp++; if (pc_o !== 32'h1C000000) begin n_fail++; $display("FAIL alu_pc: got %h want 1c000000", pc_o); end
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL alu_req0: got %b want 0", req); end
        tick();
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL alu_req1: got %b want 0", req); end
        tick();
        valid = 1'b0;
    endtask

    task automatic test_load_byte();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        logic [101:0] exp;
        run_txn(mk_bus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h103, 5'd7, 1'b1, 32'h1C000100),
                0, 1'b0, 1, 1, 32'h80FF0000, rc, oa, ob, stb, sb, w, dw, da, ms);
        exp = {5'd7, 1'b1, 32'hFFFFFF80, 32'h103, 32'h1C000100};
        n_cmp++; if (oa !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", oa); end
        n_cmp++; if (rc !== 1) begin n_fail++; $display("FAIL lb_reqs: got %0d want 1", rc); end
        n_cmp++; if (ob !== exp) begin n_fail++; $display("FAIL lb_bus: got %h want %h", ob, exp); end
        n_cmp++; if (da !== 32'h103) begin n_fail++; $display("FAIL lb_addr: got %h want 103", da); end
        run_txn(mk_bus(1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h103, 5'd7, 1'b1, 32'h1C000104),
                0, 1'b0, 1, 0, 32'h80FF0000, rc, oa, ob, stb, sb, w, dw, da, ms);
        n_cmp++; if (ob[95:64] !== 32'h00000080) begin n_fail++; $display("FAIL lbu_result: got %h want 00000080", ob[95:64]); end
        n_cmp++; if (oa !== 3) begin n_fail++; $display("FAIL lbu_latency: got %0d want 3", oa); end
    endtask

    task automatic test_store_half();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        logic [101:0] exp;
        run_txn(mk_bus(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, 32'h202, 5'd4, 1'b0, 32'h1C000200),
                0, 1'b0, 1, 1, 32'h0, rc, oa, ob, stb, sb, w, dw, da, ms);
        exp = {5'd4, 1'b0, 32'h202, 32'h202, 32'h1C000200};
        n_cmp++; if (dw !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", dw); end
        n_cmp++; if (sb !== 4'b1100) begin n_fail++; $display("FAIL sh_strb: got %b want 1100", sb); end
        n_cmp++; if (w !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", w); end
        n_cmp++; if (ob !== exp) begin n_fail++; $display("FAIL sh_bus: got %h want %h", ob, exp); end
    endtask

    task automatic test_req_stall();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        run_txn(mk_bus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h300, 5'd12, 1'b1, 32'h1C000300),
                2, 1'b1, 0, 3, 32'hDEADBEEF, rc, oa, ob, stb, sb, w, dw, da, ms);
        n_cmp++; if (rc !== 3) begin n_fail++; $display("FAIL stall_reqs: got %0d want 3", rc); end
        n_cmp++; if (oa !== 4) begin n_fail++; $display("FAIL stall_latency: got %0d want 4", oa); end
        n_cmp++; if (ob[95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_result: got %h want deadbeef", ob[95:64]); end
        n_cmp++; if (stb !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b want 1", stb); end
    endtask

    task automatic test_reset_mid_txn();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        logic [106:0] lw;
        lw = mk_bus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h400, 5'd3, 1'b1, 32'h1C000400);
        tick();
        exe_bus = lw; valid = 1'b1;
        tick();
        addr_ok = 1'b1;
        @(negedge clk);
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL rstw_req_t1: got %b want 1", req); end
        tick();
        addr_ok = 1'b0;
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL rstw_req_wait: got %b want 0", req); end
        #1;
        rst = 1'b1; valid = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0 || over !== 1'b0) begin n_fail++; $display("FAIL rstw_async: got req=%b over=%b want 0 0", req, over); end
        tick();
        rst = 1'b0; data_ok = 1'b1; rdata = 32'h99999999;
        @(negedge clk);
        n_cmp++; if (over !== 1'b0) begin n_fail++; $display("FAIL rstw_late_ok: got over=%b want 0", over); end
        tick();
        data_ok = 1'b0;
        @(negedge clk);
        n_cmp++; if (over !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: got req=%b over=%b want 0 0", req, over); end
        run_txn(lw, 0, 1'b0, 1, 0, 32'h11223344, rc, oa, ob, stb, sb, w, dw, da, ms);
        n_cmp++; if (rc !== 1 || oa !== 3) begin n_fail++; $display("FAIL rstw_fresh: got reqs=%0d over_at=%0d want 1 3", rc, oa); end
        n_cmp++; if (ob[95:64] !== 32'h11223344) begin n_fail++; $display("FAIL rstw_fresh_result: got %h want 11223344", ob[95:64]); end
        tick();
        exe_bus = lw; valid = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL rstr_req: got %b want 1", req); end
        #1;
        rst = 1'b1; valid = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL rstr_async: got %b want 0", req); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_misalign();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        run_txn(mk_bus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h102, 5'd6, 1'b1, 32'h1C000500),
                0, 1'b0, 1, 1, 32'hCAFEF00D, rc, oa, ob, stb, sb, w, dw, da, ms);
`ifdef MEM_ALIGN_CHECK_EN
        n_cmp++; if (rc !== 0) begin n_fail++; $display("FAIL mis_reqs: got %0d want 0", rc); end
        n_cmp++; if (oa !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d want 1", oa); end
        n_cmp++; if (ms !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", ms); end
        n_cmp++; if (ob[96] !== 1'b0) begin n_fail++; $display("FAIL mis_we: got %b want 0", ob[96]); end
`else
        n_cmp++; if (rc !== 1) begin n_fail++; $display("FAIL mis_reqs: got %0d want 1", rc); end
        n_cmp++; if (oa !== 3) begin n_fail++; $display("FAIL mis_latency: got %0d want 3", oa); end
        n_cmp++; if (ms !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b want 0", ms); end
        n_cmp++; if (ob[96] !== 1'b1) begin n_fail++; $display("FAIL mis_we: got %b want 1", ob[96]); end
        n_cmp++; if (ob[95:64] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_result: got %h want cafef00d", ob[95:64]); end
`endif
        @(negedge clk);
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign); end
    endtask

    task automatic test_random();
        int rc, oa; logic [101:0] ob; bit stb, ms; logic [3:0] sb; logic [31:0] w, da; logic dw;
        for (int i = 0; i < 40; i++) begin
            logic         is_ld, uns, we;
            logic [1:0]   size;
            logic [31:0]  ea, sd, pc, rd;
            logic [4:0]   wd;
            int           a_wait, d_wait, hold, exp_over;
            bit           same;
            logic [101:0] exp;
            is_ld  = 1'($urandom % 2);
            uns    = 1'($urandom % 2);
            we     = is_ld ? 1'($urandom % 2) : 1'b0;
            size   = 2'($urandom_range(0, 2));
            ea     = $urandom;
            ea     = (size == 2'd2) ? ea - (ea % 4) : (size == 2'd1) ? ea - (ea % 2) : ea;
            sd     = $urandom;
            pc     = $urandom;
            rd     = $urandom;
            wd     = 5'($urandom % 32);
            a_wait = $urandom_range(0, 3);
            same   = ($urandom % 3) == 0;
            d_wait = $urandom_range(1, 3);
            hold   = $urandom_range(0, 3);
            exp_over = a_wait + (same ? 0 : d_wait) + 2;
            exp = {wd, we, (is_ld ? ref_load(size, uns, ea, rd) : ea), ea, pc};
            run_txn(mk_bus(is_ld, ~is_ld, size, uns, sd, ea, wd, we, pc),
                    a_wait, same, d_wait, hold, rd, rc, oa, ob, stb, sb, w, dw, da, ms);
            n_cmp++; if (oa !== exp_over) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, oa, exp_over); end
            n_cmp++; if (rc !== a_wait + 1) begin n_fail++; $display("FAIL rnd%0d_reqs: got %0d want %0d", i, rc, a_wait + 1); end
            n_cmp++; if (ob !== exp) begin n_fail++; $display("FAIL rnd%0d_bus: got %h want %h", i, ob, exp); end
            n_cmp++; if (stb !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_stable: got %b want 1", i, stb); end
            n_cmp++; if (da !== ea) begin n_fail++; $display("FAIL rnd%0d_addr: got %h want %h", i, da, ea); end
            n_cmp++; if (dw !== ~is_ld) begin n_fail++; $display("FAIL rnd%0d_we: got %b want %b", i, dw, ~is_ld); end
            if (!is_ld) begin
                n_cmp++; if (sb !== ref_strb(size, ea)) begin n_fail++; $display("FAIL rnd%0d_strb: got %b want %b", i, sb, ref_strb(size, ea)); end
                n_cmp++; if (w !== ref_wdata(size, sd)) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", i, w, ref_wdata(size, sd)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_req_stall();
        test_reset_mid_txn();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
